// File: rtl/snn_wta_sequencer_if.sv
// Bus bundle between the window sequencer and its environment (spike memory,
// neuron array, top-level FSM).
interface snn_wta_sequencer_if #(
  parameter int unsigned P_NEURONS = 8,
  parameter int unsigned P_SYN     = 42,
  parameter int unsigned P_SVW     = 22,
  parameter int unsigned P_TSTEPS  = 64
);
  localparam int unsigned IdxW  = (P_NEURONS > 1) ? $clog2(P_NEURONS) : 1;
  localparam int unsigned StepW = (P_TSTEPS > 1) ? $clog2(P_TSTEPS) : 1;

  logic                       i_start;
  logic                       o_busy;
  logic                       o_done;
  logic                       o_frame_req;
  logic [StepW-1:0]           o_frame_addr;
  logic                       i_frame_valid;
  logic [P_SYN-1:0]           i_frame;
  logic [P_SYN-1:0]           o_event;
  logic [P_NEURONS*P_SVW-1:0] i_neuronout;
  logic [P_NEURONS-1:0]       o_neuron_rst_n;
  logic                       o_win_valid;
  logic [IdxW-1:0]            o_win_idx;
  logic [IdxW-1:0]            o_first_idx;
  logic                       o_fired;

  modport master (
    input  i_start, i_frame_valid, i_frame, i_neuronout,
    output o_busy, o_done, o_frame_req, o_frame_addr, o_event, o_neuron_rst_n,
           o_win_valid, o_win_idx, o_first_idx, o_fired
  );

  modport slave (
    output i_start, i_frame_valid, i_frame, i_neuronout,
    input  o_busy, o_done, o_frame_req, o_frame_addr, o_event, o_neuron_rst_n,
           o_win_valid, o_win_idx, o_first_idx, o_fired
  );
endinterface

// File: rtl/snn_wta_sequencer.sv
// Steps one inference window: fetch a spike frame, pulse it onto the event bus, let the
// neurons settle, pick a winner-take-all winner and clear the array after each win.
module snn_wta_sequencer #(
  parameter int unsigned P_NEURONS = 8,
  parameter int unsigned P_SYN     = 42,
  parameter int unsigned P_SVW     = 22,
  parameter int unsigned P_TSTEPS  = 64,
  parameter int unsigned P_SETTLE  = 3,
  parameter int unsigned P_CLR     = 2
) (
  input logic                 i_clk,
  input logic                 i_rst,
  snn_wta_sequencer_if.master bus
);
  localparam int unsigned IdxW   = (P_NEURONS > 1) ? $clog2(P_NEURONS) : 1;
  localparam int unsigned StepW  = (P_TSTEPS > 1) ? $clog2(P_TSTEPS) : 1;
  localparam int unsigned CntMax = (P_CLR > P_SETTLE) ? P_CLR : P_SETTLE;
  localparam int unsigned CntW   = $clog2(CntMax + 1);
  localparam logic [CntW-1:0]  ClrLast    = CntW'(P_CLR - 1);
  localparam logic [CntW-1:0]  SettleLast = CntW'(P_SETTLE - 1);
  localparam logic [StepW-1:0] StepLast   = StepW'(P_TSTEPS - 1);

  typedef enum logic [2:0] {
    StIdle, StClear, StFetch, StFire, StSettle, StEval, StInhib, StDone
  } state_e;

  state_e               state_q, state_d;
  logic [StepW-1:0]     step_q, step_d;
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 req_q, req_d;
  logic                 win_valid_q, win_valid_d;
  logic                 fired_q, fired_d;
  logic [P_SYN-1:0]     event_q, event_d;
  logic [P_NEURONS-1:0] nrst_q, nrst_d;
  logic [IdxW-1:0]      win_idx_q, win_idx_d;
  logic [IdxW-1:0]      first_q, first_d;

  logic             found;
  logic [P_SVW-1:0] best_val, cand_val;
  logic [IdxW-1:0]  best_idx;
  logic             advance;

  // Strict '>' keeps the lowest index on equal values.
  always_comb begin
    found    = 1'b0;
    best_val = '0;
    best_idx = '0;
    cand_val = '0;
    for (int unsigned n = 0; n < P_NEURONS; n++) begin
      cand_val = bus.i_neuronout[n*P_SVW +: P_SVW];
      if (cand_val != '0 && (!found || cand_val > best_val)) begin
        found    = 1'b1;
        best_val = cand_val;
        best_idx = IdxW'(n);
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    step_d      = step_q;
    cnt_d       = cnt_q;
    fired_d     = fired_q;
    first_d     = first_q;
    win_idx_d   = win_idx_q;
    win_valid_d = 1'b0;
    advance     = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (bus.i_start) begin
          step_d  = '0;
          fired_d = 1'b0;
          cnt_d   = '0;
          state_d = StClear;
        end
      end
      StClear: begin
        if (cnt_q == ClrLast) begin
          cnt_d   = '0;
          state_d = StFetch;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StFetch: begin
        if (bus.i_frame_valid) state_d = StFire;
      end
      StFire: begin
        cnt_d   = '0;
        state_d = StSettle;
      end
      StSettle: begin
        if (cnt_q == SettleLast) begin
          cnt_d   = '0;
          state_d = StEval;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StEval: begin
        if (found) begin
          win_valid_d = 1'b1;
          win_idx_d   = best_idx;
          if (!fired_q) begin
            first_d = best_idx;
            fired_d = 1'b1;
          end
          cnt_d   = '0;
          state_d = StInhib;
        end else begin
          advance = 1'b1;
        end
      end
      StInhib: begin
        if (cnt_q == ClrLast) begin
          cnt_d   = '0;
          advance = 1'b1;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase

    if (advance) begin
      if (step_q == StepLast) begin
        state_d = StDone;
      end else begin
        step_d  = step_q + StepW'(1);
        state_d = StFetch;
      end
    end

    // Outputs are registered copies of what the next state implies.
    busy_d  = (state_d != StIdle);
    done_d  = (state_d == StDone);
    req_d   = (state_d == StFetch);
    nrst_d  = (state_d == StClear || state_d == StInhib) ? '0 : '1;
    event_d = (state_q == StFetch && bus.i_frame_valid) ? bus.i_frame : '0;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= StIdle;
      step_q      <= '0;
      cnt_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      req_q       <= 1'b0;
      win_valid_q <= 1'b0;
      fired_q     <= 1'b0;
      event_q     <= '0;
      nrst_q      <= '0;
      win_idx_q   <= '0;
      first_q     <= '0;
    end else begin
      state_q     <= state_d;
      step_q      <= step_d;
      cnt_q       <= cnt_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      req_q       <= req_d;
      win_valid_q <= win_valid_d;
      fired_q     <= fired_d;
      event_q     <= event_d;
      nrst_q      <= nrst_d;
      win_idx_q   <= win_idx_d;
      first_q     <= first_d;
    end
  end

  assign bus.o_busy         = busy_q;
  assign bus.o_done         = done_q;
  assign bus.o_frame_req    = req_q;
  assign bus.o_frame_addr   = step_q;
  assign bus.o_event        = event_q;
  assign bus.o_neuron_rst_n = nrst_q;
  assign bus.o_win_valid    = win_valid_q;
  assign bus.o_win_idx      = win_idx_q;
  assign bus.o_first_idx    = first_q;
  assign bus.o_fired        = fired_q;
endmodule

// File: tb/tb_snn_wta_sequencer.sv
// Directed windows plus randomized frames/neuron values for snn_wta_sequencer, checked against
// a per-window model of winners, fetch order, event pulses and start->done latency.
module tb_snn_wta_sequencer;
  localparam int unsigned N   = 8;
  localparam int unsigned SYN = 42;
  localparam int unsigned SVW = 22;
  localparam int unsigned T   = 64;
  localparam int unsigned S   = 3;
  localparam int unsigned CLR = 2;
  localparam int unsigned IW  = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  snn_wta_sequencer_if #(.P_NEURONS(N), .P_SYN(SYN), .P_SVW(SVW), .P_TSTEPS(T)) bus ();

  snn_wta_sequencer #(
    .P_NEURONS(N), .P_SYN(SYN), .P_SVW(SVW), .P_TSTEPS(T), .P_SETTLE(S), .P_CLR(CLR)
  ) dut (
    .i_clk(clk),
    .i_rst(rst),
    .bus  (bus)
  );

  logic [SYN-1:0]   frames [T];
  logic [N*SVW-1:0] nv     [T];
  int               dly    [T];

  int tests_run = 0;
  int failed    = 0;

  // Monitor state
  bit          mon_en = 1'b0;
  int          cyc, done_cnt, done_cyc, ev_cycles, ev_bad, nrst0, nrst_part, req_run, req_max;
  logic        done_fired;
  logic [IW-1:0] done_first;
  logic        req_prev;
  int          addr_q[$];
  int          win_q[$];
  int          wait_cnt = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Frame memory: answers a request after dly[addr] idle cycles; junk while no request.
  always @(negedge clk) begin : responder
    logic [63:0] r;
    r = {$urandom, $urandom};
    if (bus.o_frame_req === 1'b1) begin
      if (wait_cnt >= dly[bus.o_frame_addr]) begin
        bus.i_frame_valid = 1'b1;
        bus.i_frame       = frames[bus.o_frame_addr];
      end else begin
        bus.i_frame_valid = 1'b0;
        bus.i_frame       = r[SYN-1:0];
        wait_cnt++;
      end
    end else begin
      wait_cnt          = 0;
      bus.i_frame_valid = 1'($urandom_range(0, 1));
      bus.i_frame       = r[SYN-1:0];
    end
    bus.i_neuronout = nv[bus.o_frame_addr];
  end

  always @(negedge clk) begin
    if (mon_en) begin
      cyc++;
      if (bus.o_frame_req && !req_prev) addr_q.push_back(int'(bus.o_frame_addr));
      req_run  = bus.o_frame_req ? req_run + 1 : 0;
      if (req_run > req_max) req_max = req_run;
      req_prev = bus.o_frame_req;
      if (bus.o_event != '0) begin
        ev_cycles++;
        if (bus.o_event !== frames[bus.o_frame_addr]) ev_bad++;
      end
      if (bus.o_win_valid) win_q.push_back(int'(bus.o_win_idx));
      if (bus.o_busy && bus.o_neuron_rst_n == '0) nrst0++;
      if (bus.o_neuron_rst_n != '0 && bus.o_neuron_rst_n != '1) nrst_part++;
      if (bus.o_done) begin
        done_cnt++;
        done_cyc   = cyc;
        done_fired = bus.o_fired;
        done_first = bus.o_first_idx;
      end
    end
  end

  task automatic mon_clear();
    cyc = 0; done_cnt = 0; done_cyc = 0; ev_cycles = 0; ev_bad = 0; nrst0 = 0;
    nrst_part = 0; req_run = 0; req_max = 0; req_prev = 1'b0;
    addr_q.delete(); win_q.delete();
    mon_en = 1'b1;
  endtask

  task automatic set_nv(input int s, input int n, input logic [SVW-1:0] v);
    nv[s][n*SVW +: SVW] = v;
  endtask

  task automatic gen_random(input bit with_delays);
    logic [63:0] r;
    for (int s = 0; s < int'(T); s++) begin
      r = {$urandom, $urandom};
      frames[s] = ($urandom_range(0, 3) == 0) ? '0 : r[SYN-1:0];
      dly[s]    = with_delays ? int'($urandom_range(0, 3)) : 0;
      nv[s]     = '0;
      if ($urandom_range(0, 2) == 0) begin
        for (int n = 0; n < int'(N); n++) begin
          if ($urandom_range(0, 1) == 1)
            set_nv(s, n, ($urandom_range(0, 1) == 1) ? SVW'($urandom_range(1, 4))
                                                     : SVW'($urandom_range(1, 22'h3FFFFF)));
        end
      end
    end
  endtask

  task automatic run_window(input int poke);
    @(posedge clk); #1 bus.i_start = 1'b1;
    @(posedge clk); #1 bus.i_start = 1'b0;
    mon_clear();
    for (int k = 0; k < 4000 && done_cnt == 0; k++) begin
      @(posedge clk); #1;
      bus.i_start = (poke != 0 && cyc == poke);
    end
    bus.i_start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic check_window(input string tag);
    int   exp_wins[$];
    int   exp_lat, exp_ev, exp_req, addr_bad;
    logic [SVW-1:0] v, maxv;
    exp_lat = int'(CLR) + 1;
    exp_ev  = 0;
    exp_req = 0;
    for (int s = 0; s < int'(T); s++) begin
      maxv = '0;
      for (int n = 0; n < int'(N); n++) begin
        v = nv[s][n*SVW +: SVW];
        if (v > maxv) maxv = v;
      end
      if (maxv != '0) begin
        for (int n = 0; n < int'(N); n++) begin
          if (nv[s][n*SVW +: SVW] == maxv) begin
            exp_wins.push_back(n);
            break;
          end
        end
      end
      exp_lat += dly[s] + 1 + 1 + int'(S) + 1;
      if (frames[s] != '0) exp_ev++;
      if (dly[s] + 1 > exp_req) exp_req = dly[s] + 1;
    end
    exp_lat += exp_wins.size() * int'(CLR);

    chk({tag, "_done_cnt"}, 64'(done_cnt), 64'd1);
    chk({tag, "_idle_busy"}, 64'(bus.o_busy), 64'd0);
    chk({tag, "_idle_nrst"}, 64'(bus.o_neuron_rst_n), 64'(8'hFF));
    chk({tag, "_fetch_cnt"}, 64'(addr_q.size()), 64'(T));
    addr_bad = 0;
    foreach (addr_q[i]) if (addr_q[i] != i) addr_bad++;
    chk({tag, "_fetch_order_errs"}, 64'(addr_bad), 64'd0);
    chk({tag, "_win_cnt"}, 64'(win_q.size()), 64'(exp_wins.size()));
    for (int i = 0; i < win_q.size() && i < exp_wins.size(); i++)
      chk($sformatf("%s_win%0d_idx", tag, i), 64'(win_q[i]), 64'(exp_wins[i]));
    chk({tag, "_fired"}, 64'(done_fired), 64'(exp_wins.size() != 0));
    if (exp_wins.size() != 0) chk({tag, "_first_idx"}, 64'(done_first), 64'(exp_wins[0]));
    chk({tag, "_latency"}, 64'(done_cyc), 64'(exp_lat));
    chk({tag, "_clear_cycles"}, 64'(nrst0), 64'(int'(CLR) * (1 + exp_wins.size())));
    chk({tag, "_partial_clear"}, 64'(nrst_part), 64'd0);
    chk({tag, "_event_cycles"}, 64'(ev_cycles), 64'(exp_ev));
    chk({tag, "_event_value_errs"}, 64'(ev_bad), 64'd0);
    chk({tag, "_req_max_len"}, 64'(req_max), 64'(exp_req));
  endtask

  initial begin
    bit seen;
    bus.i_start = 1'b0;
    for (int s = 0; s < int'(T); s++) begin
      frames[s] = '0; nv[s] = '0; dly[s] = 0;
    end

    // Reset values
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 64'(bus.o_busy), 64'd0);
    chk("rst_nrst", 64'(bus.o_neuron_rst_n), 64'd0);
    chk("rst_event", 64'(bus.o_event), 64'd0);
    chk("rst_req", 64'(bus.o_frame_req), 64'd0);
    chk("rst_addr", 64'(bus.o_frame_addr), 64'd0);
    chk("rst_done", 64'(bus.o_done), 64'd0);
    chk("rst_win_valid", 64'(bus.o_win_valid), 64'd0);
    chk("rst_win_idx", 64'(bus.o_win_idx), 64'd0);
    chk("rst_first_idx", 64'(bus.o_first_idx), 64'd0);
    chk("rst_fired", 64'(bus.o_fired), 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("idle_nrst_release", 64'(bus.o_neuron_rst_n), 64'(8'hFF));

    // All-zero window
    run_window(0);
    check_window("w1_zero");

    // Single win: neuron 5 at step 3
    gen_random(1'b0);
    for (int s = 0; s < int'(T); s++) nv[s] = '0;
    set_nv(3, 5, 22'h100);
    run_window(0);
    check_window("w2_single");

    // Tie -> lowest index; larger value beats lower index
    for (int s = 0; s < int'(T); s++) nv[s] = '0;
    set_nv(10, 2, 22'h3FF); set_nv(10, 6, 22'h3FF);
    set_nv(20, 2, 22'h3FF); set_nv(20, 6, 22'h400);
    run_window(0);
    check_window("w3_tie");

    // Random contents, slow fetches (one 7-cycle stall), i_start poked while busy
    gen_random(1'b1);
    dly[5] = 7;
    run_window(100);
    check_window("w4_rand");

    // Reset in the middle of SETTLE
    gen_random(1'b0);
    frames[0] = 42'h155_5555_5555;
    @(posedge clk); #1 bus.i_start = 1'b1;
    @(posedge clk); #1 bus.i_start = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 50 && !seen; k++) begin
      @(posedge clk); #1;
      if (bus.o_event != '0) seen = 1'b1;
    end
    chk("w5_fire_seen", 64'(seen), 64'd1);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1;
    chk("w5_rst_busy", 64'(bus.o_busy), 64'd0);
    chk("w5_rst_nrst", 64'(bus.o_neuron_rst_n), 64'd0);
    chk("w5_rst_event", 64'(bus.o_event), 64'd0);
    chk("w5_rst_req", 64'(bus.o_frame_req), 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Fresh window after the abort must start again at address 0
    gen_random(1'b1);
    run_window(0);
    check_window("w6_after_rst");

    $display("[TB] %0d tests run, %0d failed", tests_run, failed);
    $finish;
  end
endmodule
